// File: rtl/instr_rom_bank.sv
// Instruction ROM bank: a writable word array served by a fixed-latency fetch pipeline,
// with a loader port that drains outstanding fetches before it takes over the array.
module instr_rom_bank #(
    parameter int                 PC_W    = 30,
    parameter int                 INSTR_W = 16,
    parameter int                 DEPTH   = 64,
    parameter int                 LAT     = 1,
    parameter logic [INSTR_W-1:0] NOP     = '0
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       req_valid,
    input  logic [PC_W-1:0]            req_pc,
    output logic                       req_ready,
    input  logic                       flush,
    output logic                       rsp_valid,
    output logic [INSTR_W-1:0]         rsp_instr,
    output logic [1:0]                 rsp_err,
    input  logic                       ld_valid,
    input  logic [$clog2(DEPTH)-1:0]   ld_addr,
    input  logic [INSTR_W-1:0]         ld_data,
    input  logic                       ld_last,
    output logic                       ld_ready
);
    localparam int AW    = $clog2(DEPTH);
    localparam int BYTES = INSTR_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, DRAIN, LOAD} state_t;

    state_t state, state_nxt;

    logic [INSTR_W-1:0] mem [DEPTH];

    logic [LAT-1:0]     vld_p;
    logic [1:0]         err_p   [LAT];
    logic [INSTR_W-1:0] instr_p [LAT];
    logic [INSTR_W-1:0] instr_hold;

    logic            accept;
    logic [PC_W-1:0] word_idx;
    logic [1:0]      req_err;
    logic            more_inflight;
    logic            ld_in_range;

    assign word_idx   = req_pc >> OFF_W;
    assign req_err[0] = |(req_pc & PC_W'(BYTES - 1));
    assign req_err[1] = (word_idx >= PC_W'(DEPTH));
    assign accept     = req_valid && req_ready;
    assign ld_in_range = (32'(ld_addr) < 32'(DEPTH));

    // Fetches still outstanding after this cycle: the last stage issues now, flush kills all.
    always_comb begin
        more_inflight = 1'b0;
        for (int i = 0; i < LAT - 1; i++) more_inflight = more_inflight | vld_p[i];
        if (flush) more_inflight = 1'b0;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        ld_ready  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = sys_rst_n && !ld_valid;
                if (ld_valid) state_nxt = more_inflight ? DRAIN : LOAD;
            end
            DRAIN: begin
                if (!more_inflight) state_nxt = LOAD;
            end
            LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid && ld_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            vld_p      <= '0;
            instr_hold <= '0;
        end else begin
            state    <= state_nxt;
            vld_p[0] <= accept;
            for (int i = 1; i < LAT; i++) vld_p[i] <= vld_p[i-1] && !flush;
            if (rsp_valid) instr_hold <= instr_p[LAT-1];
        end
    end

    // Stage 0: decode errors and read the array only for clean fetches
    always_ff @(posedge sys_clk) begin
        if (accept) begin
            err_p[0] <= req_err;
            if (req_err == 2'b00) instr_p[0] <= mem[word_idx[AW-1:0]];
            else                  instr_p[0] <= NOP;
        end
        // Stages 1..LAT-1: pure delay, data moves only behind a valid entry
        for (int i = 1; i < LAT; i++) begin
            if (vld_p[i-1]) begin
                err_p[i]   <= err_p[i-1];
                instr_p[i] <= instr_p[i-1];
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (ld_valid && ld_ready && ld_in_range) mem[ld_addr] <= ld_data;
    end

    assign rsp_valid = vld_p[LAT-1] && !flush;
    assign rsp_err   = rsp_valid ? err_p[LAT-1] : 2'b00;
    assign rsp_instr = rsp_valid ? instr_p[LAT-1] : instr_hold;

endmodule

// File: tb/tb_instr_rom_bank.sv
// Bench for instr_rom_bank: a LAT=1/DEPTH=64 bank and a LAT=3/DEPTH=48 bank, driven in turn
// and compared every cycle against a queue-based model of fetches, loads, flushes and resets.
module tb_instr_rom_bank;
    localparam int M_IDLE = 0;
    localparam int M_DRAIN = 1;
    localparam int M_LOAD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        req_valid, flush, ld_valid, ld_last;
    logic [29:0] req_pc;
    logic [5:0]  ld_addr;
    logic [15:0] ld_data;

    logic        a_req_valid, a_flush, a_ld_valid, a_req_ready, a_rsp_valid, a_ld_ready;
    logic [15:0] a_rsp_instr;
    logic [1:0]  a_rsp_err;
    logic        b_req_valid, b_flush, b_ld_valid, b_req_ready, b_rsp_valid, b_ld_ready;
    logic [15:0] b_rsp_instr;
    logic [1:0]  b_rsp_err;
    logic        o_req_ready, o_rsp_valid, o_ld_ready;
    logic [15:0] o_rsp_instr;
    logic [1:0]  o_rsp_err;

    assign a_req_valid = req_valid && !sel;
    assign a_flush     = flush && !sel;
    assign a_ld_valid  = ld_valid && !sel;
    assign b_req_valid = req_valid && sel;
    assign b_flush     = flush && sel;
    assign b_ld_valid  = ld_valid && sel;

    assign o_req_ready = sel ? b_req_ready : a_req_ready;
    assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign o_ld_ready  = sel ? b_ld_ready  : a_ld_ready;
    assign o_rsp_instr = sel ? b_rsp_instr : a_rsp_instr;
    assign o_rsp_err   = sel ? b_rsp_err   : a_rsp_err;

    always #5 clk = ~clk;

    instr_rom_bank #(.PC_W(30), .INSTR_W(16), .DEPTH(64), .LAT(1), .NOP(16'h0000)) u_dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .req_valid(a_req_valid), .req_pc(req_pc),
        .req_ready(a_req_ready), .flush(a_flush), .rsp_valid(a_rsp_valid),
        .rsp_instr(a_rsp_instr), .rsp_err(a_rsp_err), .ld_valid(a_ld_valid),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(a_ld_ready));

    instr_rom_bank #(.PC_W(30), .INSTR_W(16), .DEPTH(48), .LAT(3), .NOP(16'hE000)) u_dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .req_valid(b_req_valid), .req_pc(req_pc),
        .req_ready(b_req_ready), .flush(b_flush), .rsp_valid(b_rsp_valid),
        .rsp_instr(b_rsp_instr), .rsp_err(b_rsp_err), .ld_valid(b_ld_valid),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(b_ld_ready));

    typedef struct {
        int          due;
        logic [15:0] instr;
        logic [1:0]  err;
    } rsp_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          mode = M_IDLE;
    rsp_t        q[$];
    logic [15:0] last = '0;
    logic [15:0] mm [2][64];
    bit          hs_ld;
    logic [15:0] spec_words [7];

    function automatic int m_lat();   return sel ? 3 : 1;    endfunction
    function automatic int m_depth(); return sel ? 48 : 64;  endfunction
    function automatic logic [15:0] m_nop(); return sel ? 16'hE000 : 16'h0000; endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (bank %0d, cycle %0d)", tag, obs, exp, sel, cyc);
        end
    endtask

    task automatic check_outputs();
        logic        e_rr, e_lr, e_v;
        logic [15:0] e_i;
        logic [1:0]  e_e;
        bit          due;
        due = (q.size() > 0) && (q[0].due == cyc);
        if (!rst_n) begin
            e_rr = 1'b0; e_lr = 1'b0; e_v = 1'b0; e_i = '0; e_e = '0;
        end else begin
            e_rr = (mode == M_IDLE) && !ld_valid;
            e_lr = (mode == M_LOAD);
            e_v  = due && !flush;
            e_i  = e_v ? q[0].instr : last;
            e_e  = e_v ? q[0].err : 2'b00;
        end
        chk("req_ready", 32'(o_req_ready), 32'(e_rr));
        chk("ld_ready",  32'(o_ld_ready),  32'(e_lr));
        chk("rsp_valid", 32'(o_rsp_valid), 32'(e_v));
        chk("rsp_instr", 32'(o_rsp_instr), 32'(e_i));
        chk("rsp_err",   32'(o_rsp_err),   32'(e_e));
    endtask

    task automatic model_update();
        bit   due;
        int   remaining, idx, s;
        rsp_t r;
        s = sel ? 1 : 0;
        if (!rst_n) begin
            mode = M_IDLE;
            q.delete();
            last = '0;
            cyc++;
            return;
        end
        due = (q.size() > 0) && (q[0].due == cyc);
        if (due) begin
            if (!flush) last = q[0].instr;
            void'(q.pop_front());
        end
        if (flush) q.delete();
        remaining = q.size();
        if (req_valid && mode == M_IDLE && !ld_valid) begin
            idx      = int'(req_pc >> 1);
            r.err[0] = req_pc[0];
            r.err[1] = (idx >= m_depth());
            r.instr  = (r.err != 2'b00) ? m_nop() : mm[s][idx];
            r.due    = cyc + m_lat();
            q.push_back(r);
        end
        case (mode)
            M_IDLE:  if (ld_valid) mode = (remaining > 0) ? M_DRAIN : M_LOAD;
            M_DRAIN: if (remaining == 0) mode = M_LOAD;
            default: if (ld_valid) begin
                if (int'(ld_addr) < m_depth()) mm[s][ld_addr] = ld_data;
                if (ld_last) mode = M_IDLE;
            end
        endcase
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        hs_ld = ld_valid && o_ld_ready;
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = 1'b0; flush = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        req_pc = '0; ld_addr = '0; ld_data = '0;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_word(input int addr, input logic [15:0] d, input bit is_last);
        int guard;
        guard = 0;
        ld_valid = 1'b1; ld_addr = 6'(addr); ld_data = d; ld_last = is_last;
        do begin
            step();
            guard++;
        end while (!hs_ld && guard < 20);
        chk("ld_handshake", 32'(hs_ld), 32'd1);
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    function automatic logic [29:0] rand_pc(input int depth);
        int k;
        k = int'($urandom_range(0, 5));
        case (k)
            0, 1, 2: return 30'($urandom_range(0, depth - 1) * 2);
            3:       return 30'($urandom_range(0, depth - 1) * 2 + 1);
            4:       return 30'($urandom_range(depth, 4 * depth) * 2 + $urandom_range(0, 1));
            default: return 30'($urandom);
        endcase
    endfunction

    task automatic random_phase(input int n);
        for (int k = 0; k < n; k++) begin
            req_valid = ($urandom_range(0, 1) == 1);
            req_pc    = rand_pc(m_depth());
            flush     = ($urandom_range(0, 9) == 0);
            ld_valid  = ($urandom_range(0, 6) == 0);
            ld_last   = ($urandom_range(0, 2) == 0);
            ld_addr   = 6'($urandom_range(0, 63));
            ld_data   = 16'($urandom);
            step();
        end
        idle(6);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        spec_words = '{16'h5CCD, 16'h1234, 16'h9200, 16'h9A00, 16'h8DAE, 16'hB000, 16'hB80E};
        sel = 1'b0;
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;

        // ---------------- bank A: LAT=1, DEPTH=64 ----------------
        step(); step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 64; i++) load_word(i, 16'($urandom), i == 63);
        for (int i = 0; i < 7; i++) load_word(i, spec_words[i], i == 6);
        for (int i = 0; i < 7; i++) begin
            req_valid = 1'b1; req_pc = 30'(2 * i);
            step();
        end
        idle(3);
        req_valid = 1'b1; req_pc = 30'd3;   step();
        req_pc = 30'd128;                   step();
        idle(3);
        load_word(10, 16'hA5A5, 1'b1);
        req_valid = 1'b1; req_pc = 30'd20;  step();
        idle(2);
        req_valid = 1'b1; req_pc = 30'd4;   step();
        req_pc = 30'd6; flush = 1'b1;       step();
        idle(3);
        random_phase(300);

        // ---------------- bank B: LAT=3, DEPTH=48 ----------------
        sel = 1'b1;
        clear_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 48; i++) begin
            if (i == 20) load_word(50, 16'hBAD0, 1'b0);
            load_word(i, 16'($urandom), i == 47);
        end
        req_valid = 1'b1; req_pc = 30'd3;   step();
        req_pc = 30'd96;                    step();
        idle(5);
        req_valid = 1'b1; req_pc = 30'd0;   step();
        req_pc = 30'd2;                     step();
        req_pc = 30'd4; flush = 1'b1;       step();
        idle(5);
        req_valid = 1'b1; req_pc = 30'd2;   step();
        req_pc = 30'd4;                     step();
        req_valid = 1'b0;
        load_word(5, 16'hCAFE, 1'b1);
        req_valid = 1'b1; req_pc = 30'd10;  step();
        idle(5);
        load_word(0, 16'h1111, 1'b0);
        load_word(1, 16'h2222, 1'b0);
        load_word(2, 16'h3333, 1'b0);
        load_word(3, 16'h7777, 1'b0);
        ld_valid = 1'b1; ld_addr = 6'd4; ld_data = 16'h4444; ld_last = 1'b1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        clear_inputs();
        step();
        req_valid = 1'b1; req_pc = 30'd6;   step();
        req_pc = 30'd8;                     step();
        idle(5);
        random_phase(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
